// File: rtl/program_loader_pkg.sv
// Shared architecture definitions for the boot path: instruction encodings
// used by the loader and its bench, plus the loader state encoding.
package program_loader_pkg;

  localparam int INST_WIDTH_DEF = 16;

  // Instruction format: [15:12] opcode, [11:8] destination register, [7:0] immediate.
  localparam logic [3:0]  OP_NOP    = 4'h0;
  localparam logic [3:0]  OP_LOADC  = 4'h1;
  localparam logic [3:0]  OP_HALT   = 4'hF;
  localparam logic [15:0] NOP_INST  = {OP_NOP, 12'h000};
  localparam logic [15:0] HALT_INST = {OP_HALT, 12'h000};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4
  } loader_state_t;

  function automatic logic [15:0] enc_loadc(input logic [3:0] rd, input logic [7:0] imm);
    return {OP_LOADC, rd, imm};
  endfunction

endpackage

// File: rtl/program_loader.sv
// Boot stage: fills program memory with HALT, streams a program in from
// address 0, then releases the core from reset after a short hold.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int INST_WIDTH      = INST_WIDTH_DEF,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int RESET_HOLD      = 4,
  parameter logic [INST_WIDTH-1:0] HALT_WORD = INST_WIDTH'(HALT_INST)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [INST_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       mem_write_enable,
  output logic [PROG_ADDR_WIDTH-1:0] mem_address,
  output logic [INST_WIDTH-1:0]      mem_write_data,
  output logic                       core_reset,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [PROG_ADDR_WIDTH:0]   word_count,
  output logic [2:0]                 state
);

  localparam int DEPTH = 1 << PROG_ADDR_WIDTH;
  localparam int CW    = PROG_ADDR_WIDTH + 1;

  // Stream handshake: a word transfers on a rising edge where in_valid and
  // in_ready are both 1; in_ready is registered and is high exactly in LOAD.

  loader_state_t st, st_nxt;

  // One counter serves as the CLEAR address, the LOAD address and the HOLD timer.
  logic [CW-1:0]              cnt, cnt_nxt;
  logic [CW-1:0]              wc_nxt;
  logic                       ovf_nxt;
  logic                       we_nxt;
  logic [PROG_ADDR_WIDTH-1:0] addr_nxt;
  logic [INST_WIDTH-1:0]      data_nxt;

  logic accept, clear_last, hold_last, full;

  assign accept     = in_valid & in_ready;
  assign clear_last = (cnt == CW'(DEPTH - 1));
  assign hold_last  = (cnt == CW'(RESET_HOLD - 1));
  assign full       = (cnt == CW'(DEPTH));
  assign state      = st;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st               <= ST_IDLE;
      cnt              <= '0;
      word_count       <= '0;
      overflow         <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      in_ready         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      core_reset       <= 1'b0;
    end else begin
      st               <= st_nxt;
      cnt              <= cnt_nxt;
      word_count       <= wc_nxt;
      overflow         <= ovf_nxt;
      mem_write_enable <= we_nxt;
      mem_address      <= addr_nxt;
      mem_write_data   <= data_nxt;
      in_ready         <= (st_nxt == ST_LOAD);
      busy             <= (st_nxt == ST_CLEAR) || (st_nxt == ST_LOAD) || (st_nxt == ST_HOLD);
      done             <= (st_nxt == ST_RUN);
      core_reset       <= (st_nxt == ST_RUN);
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:  if (start)             st_nxt = ST_CLEAR;
      ST_CLEAR: if (clear_last)        st_nxt = ST_LOAD;
      ST_LOAD:  if (accept && in_last) st_nxt = ST_HOLD;
      ST_HOLD:  if (hold_last)         st_nxt = ST_RUN;
      ST_RUN:   if (start)             st_nxt = ST_CLEAR;
      default:                         st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt  = cnt;
    wc_nxt   = word_count;
    ovf_nxt  = overflow;
    we_nxt   = 1'b0;
    addr_nxt = mem_address;
    data_nxt = mem_write_data;
    case (st)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          cnt_nxt = '0;
          wc_nxt  = '0;
          ovf_nxt = 1'b0;
        end
      end
      ST_CLEAR: begin
        we_nxt   = 1'b1;
        addr_nxt = cnt[PROG_ADDR_WIDTH-1:0];
        data_nxt = HALT_WORD;
        cnt_nxt  = clear_last ? '0 : cnt + CW'(1);
      end
      ST_LOAD: begin
        if (accept) begin
          if (!full) begin
            we_nxt   = 1'b1;
            addr_nxt = cnt[PROG_ADDR_WIDTH-1:0];
            data_nxt = in_data;
            cnt_nxt  = cnt + CW'(1);
            wc_nxt   = cnt + CW'(1);
          end else begin
            ovf_nxt = 1'b1;
          end
          // The counter becomes the hold timer once the last word is seen.
          if (in_last) cnt_nxt = '0;
        end
      end
      ST_HOLD: cnt_nxt = cnt + CW'(1);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a 1024-word and a 16-word instance share
// the stimulus bus, selected by sel; memory models and a write log back the checks.
module tb_program_loader;
  import program_loader_pkg::*;

  logic        clock = 1'b0;
  logic        reset, start, in_valid, in_last, sel;
  logic [15:0] in_data;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  logic        r10, we10, cr10, busy10, done10, ovf10;
  logic [9:0]  a10;
  logic [15:0] d10;
  logic [10:0] wc10;
  logic [2:0]  st10;
  logic        r4, we4, cr4, busy4, done4, ovf4;
  logic [3:0]  a4;
  logic [15:0] d4;
  logic [4:0]  wc4;
  logic [2:0]  st4;

  program_loader #(.INST_WIDTH(16), .PROG_ADDR_WIDTH(10), .RESET_HOLD(4)) dut10 (
    .clock(clock), .reset(reset), .start(start & ~sel), .in_data(in_data),
    .in_valid(in_valid & ~sel), .in_last(in_last), .in_ready(r10),
    .mem_write_enable(we10), .mem_address(a10), .mem_write_data(d10),
    .core_reset(cr10), .busy(busy10), .done(done10), .overflow(ovf10),
    .word_count(wc10), .state(st10));

  program_loader #(.INST_WIDTH(16), .PROG_ADDR_WIDTH(4), .RESET_HOLD(4)) dut4 (
    .clock(clock), .reset(reset), .start(start & sel), .in_data(in_data),
    .in_valid(in_valid & sel), .in_last(in_last), .in_ready(r4),
    .mem_write_enable(we4), .mem_address(a4), .mem_write_data(d4),
    .core_reset(cr4), .busy(busy4), .done(done4), .overflow(ovf4),
    .word_count(wc4), .state(st4));

  logic [15:0] mem10 [1024];
  logic [15:0] mem4  [16];
  int          log_addr [$];
  logic [15:0] log_data [$];
  logic [15:0] exp_q    [$];

  // Program memories plus a log of every non-HALT write, in commit order.
  always @(posedge clock) begin
    if (we10) mem10[a10] <= d10;
    if (we4)  mem4[a4]   <= d4;
    if (we10 && d10 !== HALT_INST) begin log_addr.push_back(int'(a10)); log_data.push_back(d10); end
    if (we4  && d4  !== HALT_INST) begin log_addr.push_back(int'(a4));  log_data.push_back(d4);  end
  end

  function automatic logic cur_ready(); return sel ? r4 : r10; endfunction
  function automatic logic cur_cr();    return sel ? cr4 : cr10; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(output int c);
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 c = cyc;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_ready(output int c);
    int n = 0;
    while (!cur_ready() && n < 3000) begin @(negedge clock); n++; end
    c = cyc;
    chk("ready_timeout", 32'(n < 3000), 1);
  endtask

  task automatic send_word(input logic [15:0] d, input logic last, output int acc);
    int n = 0;
    in_data = d; in_valid = 1'b1; in_last = last;
    while (!cur_ready() && n < 100) begin @(negedge clock); n++; end
    @(posedge clock); #1 acc = cyc;
    @(negedge clock); in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_release(input int acc, input string tag);
    int n = 0;
    while (!cur_cr() && n < 100) begin @(negedge clock); n++; end
    chk(tag, cyc - acc, 4);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, log_addr.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_addr.size(); i++) begin
      chk({tag, "_addr"}, log_addr[i], i);
      chk({tag, "_data"}, log_data[i], exp_q[i]);
    end
    log_addr.delete(); log_data.delete(); exp_q.delete();
  endtask

  initial begin
    logic [3:0]  consts [8];
    logic [15:0] prog   [10];
    int t0, t1, acc, bad;
    consts = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hA, 4'hB, 4'hE};
    for (int i = 0; i < 8; i++) prog[i] = enc_loadc(4'(i), {4'h0, consts[i]});
    prog[8] = NOP_INST; prog[9] = NOP_INST;

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; sel = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_mem_outs", {5'd0, we10, a10, d10}, 0);
    chk("reset_ctl_outs", {13'd0, r10, cr10, busy10, done10, ovf10, wc10, st10}, 0);
    chk("reset_dut4", {cr4, r4, busy4, st4}, 0);
    @(negedge clock); reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_state", st10, ST_IDLE);
    chk("idle_outs", {r10, cr10, busy10, done10}, 0);

    // Full-depth instance: 10-word program.
    pulse_start(t0);
    chk("clear_busy", busy10, 1);
    wait_ready(t1);
    chk("clear_len", t1 - t0, 1024);
    chk("load_state", st10, ST_LOAD);
    for (int i = 0; i < 10; i++) begin
      send_word(prog[i], i == 9, acc);
      exp_q.push_back(prog[i]);
    end
    wait_release(acc, "hold_len");
    chk("run_flags", {done10, busy10, ovf10}, 3'b100);
    chk("run_state", st10, ST_RUN);
    chk("wc_10", wc10, 10);
    check_log("prog10");
    for (int i = 0; i < 8; i++) chk("core_reg", {mem10[i][15:8], mem10[i][3:0]}, {OP_LOADC, 4'(i), consts[i]});
    bad = 0;
    for (int i = 10; i < 1024; i++) if (mem10[i] !== HALT_INST) bad++;
    chk("halt_fill_10", bad, 0);

    // Reload from RUN with in_valid toggling every other cycle.
    pulse_start(t0);
    chk("restart_outs", {cr10, done10, busy10}, 3'b001);
    wait_ready(t1);
    chk("reclear_len", t1 - t0, 1024);
    for (int i = 0; i < 4; i++) begin
      send_word(16'h5A00 + 16'(i), i == 3, acc);
      exp_q.push_back(16'h5A00 + 16'(i));
      if (i < 3) @(negedge clock);
    end
    wait_release(acc, "hold_len_gap");
    chk("wc_gap", wc10, 4);
    check_log("gap");
    bad = 0;
    for (int i = 4; i < 1024; i++) if (mem10[i] !== HALT_INST) bad++;
    chk("reclear_halt", bad, 0);

    // 16-word instance: 17-word stream, with start pulses in CLEAR and HOLD.
    sel = 1'b1;
    pulse_start(t0);
    repeat (3) @(negedge clock);
    start = 1'b1; @(negedge clock); start = 1'b0;
    wait_ready(t1);
    chk("clear_len_4", t1 - t0, 16);
    for (int i = 0; i < 17; i++) begin
      send_word(16'h2000 + 16'(i), i == 16, acc);
      if (i < 16) exp_q.push_back(16'h2000 + 16'(i));
    end
    start = 1'b1; @(negedge clock); start = 1'b0;
    wait_release(acc, "hold_len_4");
    chk("ovf_set", ovf4, 1);
    chk("wc_sat", wc4, 16);
    chk("run_4", {done4, st4}, {1'b1, ST_RUN});
    check_log("ovf");

    // Single-word reload clears overflow and rewrites HALT everywhere else.
    pulse_start(t0);
    chk("ovf_cleared", {ovf4, cr4, done4, wc4}, 0);
    wait_ready(t1);
    chk("clear_len_4b", t1 - t0, 16);
    send_word(16'h3ABC, 1'b1, acc);
    exp_q.push_back(16'h3ABC);
    wait_release(acc, "hold_len_1w");
    chk("wc_1w", {ovf4, wc4}, 6'd1);
    check_log("one");
    chk("mem4_word0", mem4[0], 16'h3ABC);
    bad = 0;
    for (int i = 1; i < 16; i++) if (mem4[i] !== HALT_INST) bad++;
    chk("halt_fill_4", bad, 0);

    // Asynchronous reset in the middle of LOAD.
    sel = 1'b0;
    pulse_start(t0);
    wait_ready(t1);
    send_word(16'h7001, 1'b0, acc);
    send_word(16'h7002, 1'b0, acc);
    in_data = 16'h7003; in_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("midload_mem_outs", {5'd0, we10, a10, d10}, 0);
    chk("midload_ctl_outs", {13'd0, r10, cr10, busy10, done10, ovf10, wc10, st10}, 0);
    @(negedge clock); reset = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("post_reset_idle", {cr10, st10}, 0);
    end
    log_addr.delete(); log_data.delete(); exp_q.delete();
    pulse_start(t0);
    wait_ready(t1);
    send_word(16'h7777, 1'b1, acc);
    wait_release(acc, "hold_after_reset");
    chk("release_after_reset", cr10, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Hardware boot stage that sits directly upstream of the computer core.
- Fills program memory with the HALT instruction, then writes a program received over a valid/ready word stream starting at address 0.
- Holds the core in reset throughout loading, then releases it.
- Replaces direct poking of program memory, so the core boots the same way in simulation and on silicon.

Parameters:
- INST_WIDTH, 16, instruction word width in bits; must match the core.
- PROG_ADDR_WIDTH, 10, program memory address width; depth = 2**PROG_ADDR_WIDTH.
- RESET_HOLD, 4, cycles core_reset stays low after loading completes; minimum 1.
- HALT_WORD, HALT instruction encoding from shared definitions, fill value.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  single-cycle request to (re)load the program.
- in_data  in  INST_WIDTH  instruction word from the stream source.
- in_valid  in  1  in_data and in_last are valid.
- in_last  in  1  current word is the final program word.
- in_ready  out  1  loader accepts a word this cycle.
- mem_write_enable  out  1  program memory write strobe.
- mem_address  out  PROG_ADDR_WIDTH  program memory write address.
- mem_write_data  out  INST_WIDTH  program memory write data.
- core_reset  out  1  active-low reset to the core.
- busy  out  1  loader is in CLEAR, LOAD or HOLD.
- done  out  1  program loaded and core released.
- overflow  out  1  sticky flag: stream was longer than memory depth.
- word_count  out  PROG_ADDR_WIDTH+1  number of words written to memory.

Behaviour:
- Reset (asynchronous, reset=0) forces all outputs to 0 and state to IDLE.
  - core_reset=0 during reset, so the core stays in reset.
  - Reset mid-load aborts immediately; memory contents are undefined until the next load.
- All outputs are registered; memory writes occur on the cycle after the strobe is registered.
- IDLE:
  - core_reset=0, in_ready=0.
  - start=1 -> CLEAR; clear counter, word_count and overflow.
- CLEAR:
  - One write per cycle: mem_write_enable=1, mem_write_data=HALT_WORD, mem_address=0..depth-1 ascending.
  - After writing address depth-1 (depth cycles total) -> LOAD.
  - in_ready=0 throughout.
- LOAD:
  - in_ready=1.
  - A word is accepted when in_valid=1 and in_ready=1 on the same edge.
  - Accepted word with word_count<depth: write in_data at address word_count, then increment word_count.
  - Accepted word with word_count==depth: word is dropped, no write, overflow=1 (sticky), word_count saturates at depth.
  - Accepted word with in_last=1 (written or dropped) -> HOLD; in_ready drops to 0 the following cycle.
  - in_valid=0: no write, no state change; there is no timeout.
- HOLD:
  - core_reset=0, mem_write_enable=0.
  - Counts RESET_HOLD cycles -> RUN.
- RUN:
  - core_reset=1, done=1, busy=0.
  - Memory is not written.
  - start=1 -> CLEAR; core_reset and done fall to 0 in the next cycle.
- start is ignored in CLEAR, LOAD and HOLD.
- busy=1 exactly in CLEAR, LOAD and HOLD.
- overflow and word_count hold their values in HOLD and RUN until the next start.
- A single-word program is legal: in_last on the first word.

Decomposition:
- Shared architecture definitions hold:
  - HALT_WORD encoding and default instruction width.
  - Loader state encoding (IDLE, CLEAR, LOAD, HOLD, RUN).
- The computer top level instantiates program_loader alongside the core and program memory.
- Single module; the CLEAR address counter and LOAD address counter share one register.
- No sub-module required.

Test Plan:
- PROG_ADDR_WIDTH=10. Pulse start, then stream 10 words: LOADC R0..R7 with constants D,E,A,D,B,A,B,E, then NOP, NOP (last).
  - Addresses 0-9 hold those words; addresses 10-1023 hold HALT.
  - word_count=10, overflow=0.
  - core_reset rises exactly RESET_HOLD cycles after the last word is accepted.
  - Core registers R0..R7 then read 0xD,0xE,0xA,0xD,0xB,0xA,0xB,0xE.
- Stream with in_valid toggling every other cycle for 4 words.
  - Exactly 4 writes at addresses 0-3, with no duplicate or skipped addresses.
- PROG_ADDR_WIDTH=4, stream 17 words.
  - 16 words written, word_count=16, overflow=1.
  - 17th word is accepted but not written; loader reaches RUN.
- In RUN, pulse start and load a 1-word program.
  - core_reset falls next cycle; CLEAR rewrites all addresses to HALT.
  - Address 0 holds the new word; overflow is cleared.
- Assert reset=0 midway through LOAD.
  - All outputs are 0 within the same cycle.
  - After reset release, state is IDLE and core_reset stays 0 until a new load completes.
- Pulse start during CLEAR and during HOLD.
  - Both pulses are ignored; the sequence timing is unchanged.
